shared_ram_mp: RTL and testbench

Parametrised, multi-port, byte-writable shared data RAM for the quad-core system. It replaces the single-port, asynchronous-read data memory with a registered-read array that serves `NUM_PORTS` cores through a round-robin arbiter and a valid/ready request handshake. Each port receives a one-cycle-latency response. The block sits between the per-core load/store units and the shared data storage.

---
 rtl/ram_pkg.sv | 15 +
 rtl/rr_arbiter.sv | 43 ++++
 rtl/shared_ram_mp.sv | 117 +++++++++++
 tb/tb_shared_ram_mp.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_pkg.sv
// rtl/ram_pkg.sv - shared data RAM default sizes and byte-address helper
package ram_pkg;

  localparam int RAM_NUM_PORTS = 4;
  localparam int RAM_DATA_W    = 32;
  localparam int RAM_DEPTH     = 256;

  // Byte address to word index: byte offset dropped, upper bits wrap modulo the depth.
  function automatic logic [31:0] word_index(input logic [31:0] byte_addr, input int idx_w);
    logic [31:0] mask;
    mask = (32'd1 << idx_w) - 32'd1;
    return (byte_addr >> 2) & mask;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin single-grant arbiter owning the last-grant pointer
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  req,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_idx
);

  logic [IW-1:0] last_grant_q, last_grant_d;
  logic [IW-1:0] cand;
  logic          found;

  // Search starts one past the previous winner; the first requester found wins.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    cand    = '0;
    for (int k = 1; k <= N; k++) begin
      cand = IW'((int'(last_grant_q) + k) % N);
      if (!found && req[cand]) begin
        found     = 1'b1;
        gnt[cand] = 1'b1;
        gnt_idx   = cand;
      end
    end
    last_grant_d = found ? gnt_idx : last_grant_q;
  end

  // Pointer only moves on a granted cycle; reset value gives port 0 first priority.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant_q <= IW'(N - 1);
    end else begin
      last_grant_q <= last_grant_d;
    end
  end

endmodule

// File: rtl/shared_ram_mp.sv
// rtl/shared_ram_mp.sv - multi-port byte-writable shared RAM with one-cycle registered responses
module shared_ram_mp
  import ram_pkg::*;
#(
  parameter int NUM_PORTS = RAM_NUM_PORTS,
  parameter int DATA_W    = RAM_DATA_W,
  parameter int DEPTH     = RAM_DEPTH,
  parameter int ADDR_W    = 32
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_PORTS-1:0]            req_valid,
  output logic [NUM_PORTS-1:0]            req_ready,
  input  logic [NUM_PORTS-1:0]            req_we,
  input  logic [NUM_PORTS*ADDR_W-1:0]     req_addr,
  input  logic [NUM_PORTS*DATA_W-1:0]     req_wdata,
  input  logic [NUM_PORTS*(DATA_W/8)-1:0] req_be,
  output logic [NUM_PORTS-1:0]            rsp_valid,
  output logic [NUM_PORTS*DATA_W-1:0]     rsp_rdata
);

  localparam int BE_W = DATA_W / 8;
  localparam int IW   = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int AW   = $clog2(DEPTH);

  logic [NUM_PORTS-1:0] arb_req;
  logic [NUM_PORTS-1:0] gnt;
  logic [IW-1:0]        gnt_idx;
  logic                 any_gnt;

  logic                 sel_we;
  logic [ADDR_W-1:0]    sel_addr;
  logic [DATA_W-1:0]    sel_wdata;
  logic [BE_W-1:0]      sel_be;
  logic [AW-1:0]        sel_idx;

  logic [DATA_W-1:0]    mem_q [DEPTH];

  logic [NUM_PORTS-1:0] rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]    rdata_q, rdata_d;

  // Requests are masked during reset so nothing is granted and nothing is written.
  assign arb_req = rst ? '0 : req_valid;

  rr_arbiter #(
    .N  (NUM_PORTS),
    .IW (IW)
  ) u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (arb_req),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  assign req_ready = gnt;
  assign any_gnt   = |gnt;

  // Request mux: steer the winning port's fields onto the array.
  always_comb begin
    sel_we    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    sel_be    = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (IW'(p) == gnt_idx) begin
        sel_we    = req_we[p];
        sel_addr  = req_addr[p*ADDR_W +: ADDR_W];
        sel_wdata = req_wdata[p*DATA_W +: DATA_W];
        sel_be    = req_be[p*BE_W +: BE_W];
      end
    end
    sel_idx = AW'(word_index(32'(sel_addr), AW));
  end

  // Byte-lane write at the accepting edge; storage itself is never reset.
  always_ff @(posedge clk) begin
    if (any_gnt && sel_we) begin
      for (int k = 0; k < BE_W; k++) begin
        if (sel_be[k]) begin
          mem_q[sel_idx][k*8 +: 8] <= sel_wdata[k*8 +: 8];
        end
      end
    end
  end

  // Response next state: pulse to the winner, pre-access word for reads, zero for writes.
  always_comb begin
    rsp_valid_d = gnt;
    rdata_d     = '0;
    if (any_gnt && !sel_we) begin
      rdata_d = mem_q[sel_idx];
    end
  end

  // Response register; reset discards any pending response.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid_q <= '0;
      rdata_q     <= '0;
    end else begin
      rsp_valid_q <= rsp_valid_d;
      rdata_q     <= rdata_d;
    end
  end

  // Response demux: only the responding port sees data, all others read zero.
  always_comb begin
    rsp_rdata = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      rsp_rdata[p*DATA_W +: DATA_W] = rsp_valid_q[p] ? rdata_q : '0;
    end
  end

  assign rsp_valid = rsp_valid_q;

endmodule

// File: tb/tb_shared_ram_mp.sv
// tb/tb_shared_ram_mp.sv - self-checking bench for shared_ram_mp
module tb_shared_ram_mp;

  localparam int NP    = 4;
  localparam int DEPTH = 256;

  logic         clk = 1'b0;
  logic         rst;
  logic [3:0]   req_valid, req_ready, req_we, rsp_valid;
  logic [127:0] req_addr, req_wdata, rsp_rdata;
  logic [15:0]  req_be;

  logic [31:0]  a_addr  [NP];
  logic [31:0]  a_wdata [NP];
  logic [3:0]   a_be    [NP];

  // reference model state
  logic [31:0]  mmem [DEPTH];
  int           last;
  logic [3:0]   exp_vld;
  logic [127:0] exp_rdata;
  int           dut_g;
  int           pulses [NP];
  int           checks;
  int           errors;

  typedef struct {
    int          port;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl [10];

  always #5 clk = ~clk;

  always_comb begin
    req_addr  = '0;
    req_wdata = '0;
    req_be    = '0;
    for (int p = 0; p < NP; p++) begin
      req_addr[p*32 +: 32]  = a_addr[p];
      req_wdata[p*32 +: 32] = a_wdata[p];
      req_be[p*4 +: 4]      = a_be[p];
    end
  end

  shared_ram_mp dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_be    (req_be),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata)
  );

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic set_req(input int p, input bit we, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] be);
    req_valid[p] = 1'b1;
    req_we[p]    = we;
    a_addr[p]    = addr;
    a_wdata[p]   = wdata;
    a_be[p]      = be;
  endtask

  // One clock: check DUT against the model at negedge, advance the model, return #1 after posedge.
  task automatic cycle(input bit hold, output int g);
    int          c;
    int          idx;
    logic [3:0]  exp_ready;
    @(negedge clk);
    g = -1;
    if (!rst) begin
      for (int k = 1; k <= NP; k++) begin
        c = (last + k) % NP;
        if (g < 0 && req_valid[c]) g = c;
      end
    end
    exp_ready = (g >= 0) ? 4'(1 << g) : 4'd0;
    check("req_ready", 128'(req_ready), 128'(exp_ready));
    check("rsp_valid", 128'(rsp_valid), 128'(exp_vld));
    check("rsp_rdata", rsp_rdata, exp_rdata);
    dut_g = -1;
    for (int p = 0; p < NP; p++) begin
      if (req_ready[p]) dut_g = p;
      if (rsp_valid[p]) pulses[p]++;
    end
    exp_vld   = '0;
    exp_rdata = '0;
    if (rst) begin
      last = NP - 1;
    end else if (g >= 0) begin
      idx = int'((a_addr[g] / 32'd4) % 32'd256);
      if (req_we[g]) begin
        for (int b = 0; b < 4; b++)
          if (a_be[g][b]) mmem[idx][b*8 +: 8] = a_wdata[g][b*8 +: 8];
      end else begin
        exp_rdata[g*32 +: 32] = mmem[idx];
      end
      exp_vld[g] = 1'b1;
      last       = g;
    end
    @(posedge clk);
    #1;
    if (g >= 0 && !hold) req_valid[g] = 1'b0;
  endtask

  task automatic single(input int p, input bit we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] be,
                        output logic [31:0] got, output bit ok);
    int g;
    int n;
    set_req(p, we, addr, wdata, be);
    ok = 1'b0;
    n  = 0;
    while (!ok && n < 8) begin
      cycle(1'b0, g);
      n++;
      if (g == p) ok = 1'b1;
    end
    got = rsp_rdata[p*32 +: 32];
    req_valid[p] = 1'b0;
  endtask

  initial begin
    int          g;
    logic [31:0] got;
    bit          ok;
    logic [31:0] addr;

    checks = 0; errors = 0; last = NP - 1; exp_vld = '0; exp_rdata = '0; dut_g = -1;
    rst = 1'b1;
    req_valid = '0;
    req_we    = '0;
    for (int p = 0; p < NP; p++) begin
      a_addr[p] = '0; a_wdata[p] = '0; a_be[p] = '0; pulses[p] = 0;
    end

    tbl[0] = '{2, 1'b1, 32'h40,  32'hDEADBEEF, 4'hF, 32'h0};
    tbl[1] = '{2, 1'b0, 32'h40,  32'h0,        4'h0, 32'hDEADBEEF};
    tbl[2] = '{0, 1'b1, 32'h80,  32'h11223344, 4'hF, 32'h0};
    tbl[3] = '{0, 1'b1, 32'h80,  32'hAABBCCDD, 4'h5, 32'h0};
    tbl[4] = '{1, 1'b0, 32'h80,  32'h0,        4'h0, 32'h11BB33DD};
    tbl[5] = '{3, 1'b1, 32'h004, 32'h5A5A5A5A, 4'hF, 32'h0};
    tbl[6] = '{0, 1'b0, 32'h404, 32'h0,        4'h0, 32'h5A5A5A5A};
    tbl[7] = '{2, 1'b0, 32'h007, 32'h0,        4'h0, 32'h5A5A5A5A};
    tbl[8] = '{1, 1'b1, 32'h10,  32'h12345678, 4'h0, 32'h0};
    tbl[9] = '{1, 1'b0, 32'h10,  32'h0,        4'h0, 32'hC0DE0004};

    // reset held with all four ports requesting: nothing may be accepted
    for (int p = 0; p < NP; p++) set_req(p, 1'b1, 32'(p * 4), 32'(p + 1), 4'hF);
    cycle(1'b1, g);
    cycle(1'b1, g);
    check("reset_rsp_rdata", rsp_rdata, 128'h0);
    rst = 1'b0;

    // round robin from reset: order 0,1,2,3,0,1,2,3 and two pulses per port
    for (int p = 0; p < NP; p++) pulses[p] = 0;
    for (int i = 0; i < 8; i++) begin
      cycle(1'b1, g);
      check("rr_order", 128'(dut_g), 128'(i % NP));
    end
    req_valid = '0;
    cycle(1'b0, g);
    for (int p = 0; p < NP; p++) check("rr_pulses", 128'(pulses[p]), 128'd2);

    // fill every word with a known pattern
    for (int i = 0; i < DEPTH; i++) single(0, 1'b1, 32'(i * 4), 32'hC0DE0000 | 32'(i), 4'hF, got, ok);

    // directed table
    for (int i = 0; i < 10; i++) begin
      single(tbl[i].port, tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].be, got, ok);
      check("tbl_grant", 128'(ok), 128'd1);
      check("tbl_rsp_valid", 128'(rsp_valid[tbl[i].port]), 128'd1);
      check("tbl_rdata", 128'(got), 128'(tbl[i].exp));
    end

    // contention with last grant at port 0: port 1 write wins, port 3 read sees it next cycle
    single(0, 1'b0, 32'h0, 32'h0, 4'h0, got, ok);
    set_req(1, 1'b1, 32'h100, 32'h1, 4'hF);
    set_req(3, 1'b0, 32'h100, 32'h0, 4'h0);
    cycle(1'b0, g);
    check("cont_first", 128'(dut_g), 128'd1);
    cycle(1'b0, g);
    check("cont_second", 128'(dut_g), 128'd3);
    check("cont_rdata", 128'(rsp_rdata[3*32 +: 32]), 128'h1);
    cycle(1'b0, g);

    // reset with a read response pending: dropped at once, never reappears
    set_req(1, 1'b0, 32'h40, 32'h0, 4'h0);
    cycle(1'b0, g);
    check("pre_rst_grant", 128'(dut_g), 128'd1);
    rst = 1'b1;
    #1;
    check("rst_rsp_valid", 128'(rsp_valid), 128'h0);
    check("rst_rsp_rdata", rsp_rdata, 128'h0);
    exp_vld = '0; exp_rdata = '0; last = NP - 1;
    set_req(3, 1'b0, 32'h80, 32'h0, 4'h0);
    set_req(0, 1'b0, 32'h40, 32'h0, 4'h0);
    cycle(1'b0, g);
    rst = 1'b0;
    cycle(1'b0, g);
    check("rst_first_win", 128'(dut_g), 128'd0);
    cycle(1'b0, g);
    check("rst_second_win", 128'(dut_g), 128'd3);
    cycle(1'b0, g);

    // randomized traffic against the model, with aliasing and hazards on a few words
    for (int it = 0; it < 1500; it++) begin
      for (int p = 0; p < NP; p++) begin
        if (!req_valid[p] && $urandom_range(0, 1) == 1) begin
          addr = (32'($urandom_range(0, 7)) << 2) | (32'($urandom_range(0, 3)) << 10)
               | 32'($urandom_range(0, 3));
          set_req(p, 1'($urandom_range(0, 1)), addr, $urandom, 4'($urandom_range(0, 15)));
        end
      end
      cycle(1'b0, g);
    end
    req_valid = '0;
    cycle(1'b0, g);
    cycle(1'b0, g);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
